// File: rtl/bridge_link_arbiter_if.sv
// Bus bundle between two requesters, the UART link and bridge_link_arbiter.
// slave is the arbiter's view; master is the requester/UART side.
interface bridge_link_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
);
    logic [1:0]                       req;
    logic [1:0]                       req_wen;
    logic [2*ADDR_WIDTH-1:0]          req_addr;
    logic [2*DATA_WIDTH-1:0]          req_wdata;
    logic [1:0]                       ack;
    logic [1:0]                       rvalid;
    logic [1:0]                       rerr;
    logic [DATA_WIDTH-1:0]            rdata;
    logic [DATA_WIDTH+ADDR_WIDTH:0]   u_din;
    logic                             u_en;
    logic                             u_tx_busy;
    logic                             u_rx_ready;
    logic [DATA_WIDTH-1:0]            u_dout;

    modport slave (
        input  req, req_wen, req_addr, req_wdata,
        input  u_tx_busy, u_rx_ready, u_dout,
        output ack, rvalid, rerr, rdata,
        output u_din, u_en
    );

    modport master (
        output req, req_wen, req_addr, req_wdata,
        output u_tx_busy, u_rx_ready, u_dout,
        input  ack, rvalid, rerr, rdata,
        input  u_din, u_en
    );
endinterface

// File: rtl/bridge_link_arbiter.sv
// Two-requester round-robin bridge: each request becomes one UART TX frame;
// reads then wait, bounded by TIMEOUT_CYCLES, for the UART RX byte.
//
// state      | meaning
// IDLE       | arbitrate; latch winner's request
// LAUNCH     | u_en high for one cycle with the frame on u_din
// TX_WAIT_HI | wait for the UART to report busy
// TX_WAIT_LO | wait for the UART to finish shifting
// RX_WAIT    | read only: wait for the RX byte or the timeout
// DONE       | ack (plus rvalid/rerr) pulse to the granted requester
module bridge_link_arbiter #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 12,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    bridge_link_arbiter_if.slave bus
);
    localparam int FRAME_WIDTH = DATA_WIDTH + ADDR_WIDTH + 1;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        TX_WAIT_HI,
        TX_WAIT_LO,
        RX_WAIT,
        DONE
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic                   ptr;
    logic                   gnt;
    logic                   lat_wen;
    logic [15:0]            tmo_cnt;
    logic [FRAME_WIDTH-1:0] u_din_q;
    logic                   u_en_q;
    logic [1:0]             ack_q;
    logic [1:0]             rvalid_q;
    logic [1:0]             rerr_q;
    logic [DATA_WIDTH-1:0]  rdata_q;

    logic                   gnt_sel;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [DATA_WIDTH-1:0]  sel_wdata;
    logic                   sel_wen;
    logic [FRAME_WIDTH-1:0] sel_frame;
    logic                   rx_ok;
    logic                   tmo_hit;
    logic [1:0]             gnt_oh;

    // ptr names the requester preferred on a tie: the one not granted last
    always_comb begin
        gnt_sel = ptr;
        case (bus.req)
            2'b01:   gnt_sel = 1'b0;
            2'b10:   gnt_sel = 1'b1;
            default: gnt_sel = ptr;
        endcase
        sel_addr  = gnt_sel ? bus.req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                            : bus.req_addr[ADDR_WIDTH-1:0];
        sel_wdata = gnt_sel ? bus.req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                            : bus.req_wdata[DATA_WIDTH-1:0];
        sel_wen   = gnt_sel ? bus.req_wen[1] : bus.req_wen[0];
        sel_frame = {sel_addr, sel_wen ? sel_wdata : {DATA_WIDTH{1'b0}}, sel_wen};
    end

    always_comb begin
        state_nxt = state;
        rx_ok     = 1'b0;
        tmo_hit   = 1'b0;
        case (state)
            IDLE: begin
                if (|bus.req) state_nxt = LAUNCH;
            end
            LAUNCH: begin
                state_nxt = TX_WAIT_HI;
            end
            TX_WAIT_HI: begin
                if (bus.u_tx_busy) state_nxt = TX_WAIT_LO;
            end
            TX_WAIT_LO: begin
                if (!bus.u_tx_busy) state_nxt = lat_wen ? DONE : RX_WAIT;
            end
            RX_WAIT: begin
                // a byte arriving on the timeout cycle still counts as data
                if (bus.u_rx_ready) begin
                    rx_ok     = 1'b1;
                    state_nxt = DONE;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_hit   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign gnt_oh = {gnt, ~gnt};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            gnt      <= 1'b0;
            lat_wen  <= 1'b0;
            tmo_cnt  <= '0;
            u_din_q  <= '0;
            u_en_q   <= 1'b0;
            ack_q    <= '0;
            rvalid_q <= '0;
            rerr_q   <= '0;
            rdata_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && |bus.req) begin
                gnt     <= gnt_sel;
                ptr     <= ~gnt_sel;
                lat_wen <= sel_wen;
                u_din_q <= sel_frame;
            end
            tmo_cnt  <= (state == RX_WAIT) ? tmo_cnt + 16'd1 : 16'd0;
            u_en_q   <= (state_nxt == LAUNCH);
            ack_q    <= (state_nxt == DONE) ? gnt_oh : 2'b00;
            rvalid_q <= rx_ok ? gnt_oh : 2'b00;
            rerr_q   <= tmo_hit ? gnt_oh : 2'b00;
            if (rx_ok) begin
                rdata_q <= bus.u_dout;
            end else if (tmo_hit) begin
                rdata_q <= '0;
            end
        end
    end

    assign bus.u_din  = u_din_q;
    assign bus.u_en   = u_en_q;
    assign bus.ack    = ack_q;
    assign bus.rvalid = rvalid_q;
    assign bus.rerr   = rerr_q;
    assign bus.rdata  = rdata_q;
endmodule

// File: tb/tb_bridge_link_arbiter.sv
// Directed and randomised bench for bridge_link_arbiter, checked against a
// transaction-level model of arbitration, framing, timing and read outcome.
`timescale 1ns/1ps
module tb_bridge_link_arbiter;
    localparam int DW  = 8;
    localparam int AW  = 12;
    localparam int TMO = 50;
    localparam int FW  = DW + AW + 1;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    int            last_gnt  = 1;
    logic [DW-1:0] mdl_rdata = '0;
    logic [FW-1:0] mdl_frame = '0;

    bridge_link_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    bridge_link_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check_val({tag, "_ack"},    32'(bus.ack),    32'd0);
        check_val({tag, "_rvalid"}, 32'(bus.rvalid), 32'd0);
        check_val({tag, "_rerr"},   32'(bus.rerr),   32'd0);
        check_val({tag, "_rdata"},  32'(bus.rdata),  32'(mdl_rdata));
    endtask

    // rx_at: cycle after RX_WAIT entry at which u_rx_ready is driven (-1 none)
    // rst_at: cycle after RX_WAIT entry at which reset is pulsed (-1 none)
    task automatic run_txn(input logic [1:0] rq, input logic [1:0] wen,
                           input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                           input int busy_len, input int rx_at,
                           input logic [DW-1:0] dout, input bit stray, input int rst_at);
        int            g;
        logic          w;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [1:0]    oh;
        bit            ok;
        int            resp;

        if (rq == 2'b01)      g = 0;
        else if (rq == 2'b10) g = 1;
        else                  g = 1 - last_gnt;
        last_gnt = g;
        w  = wen[g];
        ea = (g == 1) ? a1 : a0;
        ed = w ? ((g == 1) ? d1 : d0) : 8'h00;
        mdl_frame = {ea, ed, w};
        oh   = (g == 1) ? 2'b10 : 2'b01;
        ok   = (rx_at >= 0) && (rx_at + 1 <= TMO);
        resp = ok ? rx_at + 1 : TMO;

        bus.req       = rq;
        bus.req_wen   = wen;
        bus.req_addr  = {a1, a0};
        bus.req_wdata = {d1, d0};
        tick();
        check_val("launch_en",    32'(bus.u_en),  32'd1);
        check_val("launch_frame", 32'(bus.u_din), 32'(mdl_frame));
        tick();
        check_val("launch_pulse", 32'(bus.u_en), 32'd0);
        for (int b = 0; b < busy_len; b++) begin
            bus.u_tx_busy  = 1'b1;
            bus.u_rx_ready = stray && (b == busy_len / 2);
            bus.u_dout     = 8'($urandom);
            tick();
            check_val("tx_en_low", 32'(bus.u_en), 32'd0);
            check_val("tx_no_ack", 32'(bus.ack),  32'd0);
        end
        bus.u_tx_busy  = 1'b0;
        bus.u_rx_ready = 1'b0;
        tick();
        if (!w) begin
            for (int j = 0; j < resp; j++) begin
                if (j == rst_at) begin
                    rst = 1'b1;
                    bus.u_rx_ready = 1'b0;
                    tick();
                    rst = 1'b0;
                    last_gnt  = 1;
                    mdl_rdata = '0;
                    mdl_frame = '0;
                    check_val("rst_ack",    32'(bus.ack),    32'd0);
                    check_val("rst_rvalid", 32'(bus.rvalid), 32'd0);
                    check_val("rst_rerr",   32'(bus.rerr),   32'd0);
                    check_val("rst_u_en",   32'(bus.u_en),   32'd0);
                    check_val("rst_u_din",  32'(bus.u_din),  32'd0);
                    check_val("rst_rdata",  32'(bus.rdata),  32'd0);
                    bus.req = 2'b00;
                    return;
                end
                bus.u_rx_ready = (j == rx_at);
                bus.u_dout     = (j == rx_at) ? dout : 8'($urandom);
                tick();
                if (j + 1 < resp) check_val("rx_wait_no_ack", 32'(bus.ack), 32'd0);
            end
            bus.u_rx_ready = 1'b0;
            mdl_rdata = ok ? dout : 8'h00;
        end
        check_val("resp_ack",    32'(bus.ack),    32'(oh));
        check_val("resp_rvalid", 32'(bus.rvalid), (!w && ok)  ? 32'(oh) : 32'd0);
        check_val("resp_rerr",   32'(bus.rerr),   (!w && !ok) ? 32'(oh) : 32'd0);
        check_val("resp_rdata",  32'(bus.rdata),  32'(mdl_rdata));
        tick();
        check_quiet("post");
        check_val("post_u_din", 32'(bus.u_din), 32'(mdl_frame));
        bus.req = 2'b00;
    endtask

    initial begin
        logic [1:0] rq;
        logic [1:0] wen;
        int         rx_at;

        rst            = 1'b1;
        bus.req        = 2'b01;
        bus.req_wen    = 2'b01;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.u_tx_busy  = 1'b0;
        bus.u_rx_ready = 1'b0;
        bus.u_dout     = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("reset_no_launch", 32'(bus.u_en), 32'd0);
        end
        check_quiet("reset");
        check_val("reset_u_din", 32'(bus.u_din), 32'd0);
        rst = 1'b0;

        // single write straight out of reset
        run_txn(2'b01, 2'b01, 12'h123, 12'h000, 8'hA5, 8'h00, 10, -1, 8'h00, 1'b0, -1);
        // read ok, write data forced to zero in the frame
        run_txn(2'b10, 2'b00, 12'h000, 12'h0FF, 8'h00, 8'h77, 8, 19, 8'h3C, 1'b0, -1);
        // read timeout, then a stray byte must be ignored
        run_txn(2'b01, 2'b00, 12'h456, 12'h000, 8'h00, 8'h00, 5, -1, 8'h00, 1'b1, -1);
        bus.u_rx_ready = 1'b1;
        bus.u_dout     = 8'hEE;
        tick();
        bus.u_rx_ready = 1'b0;
        check_quiet("stray0");
        tick();
        check_quiet("stray1");
        check_val("stray_no_launch", 32'(bus.u_en), 32'd0);
        // byte arrives on the timeout cycle
        run_txn(2'b10, 2'b00, 12'h000, 12'h321, 8'h00, 8'h00, 3, TMO - 1, 8'h81, 1'b0, -1);
        // tie held for four transactions
        for (int i = 0; i < 4; i++)
            run_txn(2'b11, 2'b11, 12'hA00 + 12'(i), 12'hB00 + 12'(i),
                    8'(i), 8'(8'h40 + i), 2 + i, -1, 8'h00, 1'b0, -1);
        // reset in RX_WAIT, then a tie must go to requester 0
        run_txn(2'b01, 2'b00, 12'h0AB, 12'h000, 8'h00, 8'h00, 4, 30, 8'h99, 1'b0, 10);
        run_txn(2'b11, 2'b11, 12'h111, 12'h222, 8'h11, 8'h22, 3, -1, 8'h00, 1'b0, -1);

        for (int n = 0; n < 40; n++) begin
            rq    = 2'($urandom_range(1, 3));
            wen   = 2'($urandom);
            rx_at = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, TMO + 3));
            run_txn(rq, wen, 12'($urandom), 12'($urandom), 8'($urandom), 8'($urandom),
                    int'($urandom_range(1, 12)), rx_at, 8'($urandom),
                    1'($urandom), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
